// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO: counter sizing and the read-mode selector.
package fifo_pkg;

    typedef enum logic {
        READ_REGISTERED = 1'b0,
        READ_FWFT       = 1'b1
    } read_mode_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Handshake/status bundle between a FIFO (slave) and its user (master).
interface fifo_flagged_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_width(DEPTH);

    logic             clear;
    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with registered or fall-through read, threshold flags,
// occupancy count, sticky overflow/underflow and a synchronous flush.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic          clock,
    input  logic          resetn,
    fifo_flagged_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam read_mode_e MODE = (FWFT != 0) ? READ_FWFT : READ_REGISTERED;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_flagged: DEPTH must be a power of two >= 2");
        end
        if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
            $error("fifo_flagged: AFULL_LEVEL must lie in 1..DEPTH");
        end
        if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
            $error("fifo_flagged: AEMPTY_LEVEL must lie in 0..DEPTH-1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("fifo_flagged: WIDTH must be >= 1");
        end
    endgenerate

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_we;
    logic [WIDTH-1:0] w_rdata;

    assign w_full    = (r_count == FULL_C);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = bus.pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = bus.push & (~w_full | w_pop_ok);
    assign w_we      = w_push_ok & ~bus.clear;

    fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == READ_FWFT) begin : g_fwft
            assign bus.data_out  = w_empty ? '0 : w_rdata;
            assign bus.valid_out = ~w_empty;
        end else begin : g_registered
            logic [WIDTH-1:0] r_data_out;
            logic             r_valid_out;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_data_out  <= '0;
                    r_valid_out <= 1'b0;
                end else if (bus.clear) begin
                    r_data_out  <= '0;
                    r_valid_out <= 1'b0;
                end else if (w_pop_ok) begin
                    r_data_out  <= w_rdata;
                    r_valid_out <= 1'b1;
                end else begin
                    r_data_out  <= '0;
                    r_valid_out <= 1'b0;
                end
            end

            assign bus.data_out  = r_data_out;
            assign bus.valid_out = r_valid_out;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AFULL_C);
    assign bus.almost_empty = (r_count <= AEMPTY_C);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Parametrised synchronous FIFO, successor to the basic buffer used in the buff_uart TX/RX paths. It adds:
- selectable first-word-fall-through (FWFT) or registered read mode
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow flags
- a synchronous flush
It sits between the UART byte engines and the bus side.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
FWFT, 0, 0 = registered read (data one cycle after pop), 1 = head word shown combinationally
AFULL_LEVEL, DEPTH-1, almost_full asserted when count >= AFULL_LEVEL (1..DEPTH)
AEMPTY_LEVEL, 1, almost_empty asserted when count <= AEMPTY_LEVEL (0..DEPTH-1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
clear  in  1  synchronous flush, takes priority over push/pop
push  in  1  write request
data_in  in  WIDTH  write data
pop  in  1  read request
data_out  out  WIDTH  read data
valid_out  out  1  data_out holds a popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_LEVEL
almost_empty  out  1  count <= AEMPTY_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: push refused
underflow  out  1  sticky: pop refused

Behaviour:
- Reset (async, immediate on resetn low): pointers=0, count=0, data_out=0, valid_out=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_LEVEL==0 ? n/a : 0), overflow=0, underflow=0. Memory array not reset.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH naturally. Count is a separate register, not derived from pointers.
- Accept rules, evaluated on the state before the edge:
  - pop_ok = pop & !empty
  - push_ok = push & (!full | pop_ok)
  - Push while full with a same-cycle pop is accepted; count unchanged.
- Refused operations:
  - push & !push_ok: data dropped, overflow<=1.
  - pop & empty: underflow<=1, even if push in same cycle. The pushed word is stored, not bypassed.
- Count update: count + push_ok - pop_ok. Flags are combinational from the registered count.
- FWFT=0 (registered read):
  - On pop_ok, data_out<=mem[rd_ptr] and valid_out<=1 on the following edge.
  - Otherwise data_out<=0 and valid_out<=0.
  - Read latency is 1 cycle; valid_out is a single-cycle pulse per accepted pop.
- FWFT=1 (fall-through):
  - data_out = empty ? 0 : mem[rd_ptr], combinational; valid_out = !empty.
  - pop_ok consumes the displayed word.
  - A word pushed into an empty FIFO is visible the cycle after the push edge.
- clear (synchronous, takes priority):
  - Pointers and count return to 0; overflow and underflow clear; data_out and valid_out go to 0.
  - Same-cycle push/pop are ignored.
- Sticky flags clear only on reset or clear.
- Parameter legality is checked at elaboration with $error:
  - DEPTH not a power of two
  - thresholds out of range

Decomposition:
- Package fifo_pkg:
  - function cnt_width(depth) returning $clog2(depth+1)
  - enum read_mode_e {READ_REGISTERED, READ_FWFT}, used by parents to set FWFT
- Sub-module fifo_ram #(WIDTH, DEPTH):
  - simple dual-port array, one write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
  - no reset
- Control logic (pointers, count, flags, output register) stays in fifo_flagged.

Test Plan:
1. FWFT=0, DEPTH=4. Reset, push 1,2,3,4 one per cycle -> count 1..4; full=1 after 4th; almost_full=1 at count 3; data_out=0, valid_out=0 throughout.
2. Push 5 while full, no pop -> overflow=1 sticky, count stays 4. Then pop x4 -> data_out 1,2,3,4 each one cycle after pop with valid_out pulse; empty=1 after 4th; data_out=0 next cycle.
3. Pop while empty -> underflow=1, count 0, data_out 0. Pulse clear -> overflow=underflow=0, count 0.
4. Full with contents 10,11,12,13; push 14 and pop same cycle -> data_out=10, count stays 4, no overflow. Drain -> 11,12,13,14.
5. FWFT=1, DEPTH=8, AEMPTY_LEVEL=2. Push 0xA5 into empty FIFO -> next cycle data_out=0xA5, valid_out=1, almost_empty=1. Pop -> data_out=0, valid_out=0, empty=1.
6. Push 3 words, assert resetn=0 mid-clock -> outputs at reset values immediately without clock edge. Release, then pop -> underflow=1 (old contents not visible).
